// File: rtl/stateless_pipe.sv
// stateless_pipe: two-stage valid/ready packet-field ALU atom.
// Optional add/sub saturation compiled in with `define STATELESS_PIPE_SAT_EN.
module stateless_pipe #(
    parameter int WIDTH          = 32,
    parameter bit SAT_EN_DEFAULT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef STATELESS_PIPE_SAT_EN
    input  logic             sat_cfg_we,
    input  logic             sat_cfg,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] pkt_1,
    input  logic [WIDTH-1:0] pkt_2,
    input  logic [WIDTH-1:0] pkt_3,
    input  logic [WIDTH-1:0] cons_1,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o_write,
    output logic             o_illegal
);

    localparam logic [WIDTH-1:0] LP_W = WIDTH'(WIDTH);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [WIDTH-1:0] r_s1_c;
    logic [WIDTH-1:0] r_s1_k;
    logic [3:0]       r_s1_op;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_res;
    logic             r_s2_ill;

    logic             w_s2_adv;
    logic             w_accept;
    logic             w_sat;
    logic             w_imm;
    logic [WIDTH-1:0] w_rhs;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic             w_sh_ok;
    logic [WIDTH-1:0] w_res;
    logic             w_ill;

`ifdef STATELESS_PIPE_SAT_EN
    logic r_sat_en;
    logic r_s1_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_en <= SAT_EN_DEFAULT;
        end else if (sat_cfg_we) begin
            r_sat_en <= sat_cfg;
        end
    end

    assign w_sat = r_s1_sat;
`else
    // Parameter only matters when saturation is compiled in.
    localparam bit LP_SAT_OFF = SAT_EN_DEFAULT & 1'b0;
    assign w_sat = LP_SAT_OFF;
`endif

    assign w_s2_adv  = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s2_adv;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_s2_valid;
    assign o_write   = r_s2_res;
    assign o_illegal = r_s2_ill;

    assign w_imm   = (r_s1_op == 4'd5) || (r_s1_op == 4'd6);
    assign w_rhs   = w_imm ? r_s1_k : r_s1_b;
    assign w_add   = {1'b0, r_s1_a} + {1'b0, w_rhs};
    assign w_sub   = {1'b0, r_s1_a} - {1'b0, w_rhs};
    assign w_sh_ok = r_s1_k < LP_W;

    always_comb begin
        w_res = '0;
        w_ill = 1'b0;
        case (r_s1_op)
            4'd0, 4'd5: w_res = (w_sat && w_add[WIDTH]) ? '1 : w_add[WIDTH-1:0];
            4'd1, 4'd6: w_res = (w_sat && w_sub[WIDTH]) ? '0 : w_sub[WIDTH-1:0];
            4'd2:  w_res = r_s1_a & r_s1_b;
            4'd3:  w_res = r_s1_a ^ r_s1_b;
            4'd4:  w_res = r_s1_a | r_s1_b;
            4'd7:  w_res = {{(WIDTH-1){1'b0}}, r_s1_a == r_s1_b};
            4'd8:  w_res = {{(WIDTH-1){1'b0}}, r_s1_a != r_s1_b};
            4'd9:  w_res = {{(WIDTH-1){1'b0}}, r_s1_a >= r_s1_b};
            4'd10: w_res = {{(WIDTH-1){1'b0}}, r_s1_a < r_s1_b};
            4'd11: w_res = w_sh_ok ? (r_s1_a << r_s1_k) : '0;
            4'd12: w_res = w_sh_ok ? (r_s1_a >> r_s1_k) : '0;
            4'd13: w_res = (r_s1_a != '0) ? r_s1_b : r_s1_c;
            default: w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_c     <= '0;
            r_s1_k     <= '0;
            r_s1_op    <= '0;
`ifdef STATELESS_PIPE_SAT_EN
            r_s1_sat   <= 1'b0;
`endif
            r_s2_valid <= 1'b0;
            r_s2_res   <= '0;
            r_s2_ill   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= pkt_1;
                r_s1_b     <= pkt_2;
                r_s1_c     <= pkt_3;
                r_s1_k     <= cons_1;
                r_s1_op    <= opcode;
`ifdef STATELESS_PIPE_SAT_EN
                r_s1_sat   <= r_sat_en;
`endif
            end else if (w_s2_adv) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s2_adv) begin
                r_s2_valid <= 1'b1;
                r_s2_res   <= w_res;
                r_s2_ill   <= w_ill;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stateless_pipe.sv
// tb_stateless_pipe: vector table, directed flow-control sequences and
// randomized scoreboard run for stateless_pipe.
module tb_stateless_pipe;

    localparam int W = 32;
    localparam longint unsigned MAXV = 64'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] pkt_1;
    logic [W-1:0] pkt_2;
    logic [W-1:0] pkt_3;
    logic [W-1:0] cons_1;
    logic [3:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] o_write;
    logic         o_illegal;
`ifdef STATELESS_PIPE_SAT_EN
    logic         sat_cfg_we;
    logic         sat_cfg;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit m_sat   = 1'b0;

    stateless_pipe #(.WIDTH(W), .SAT_EN_DEFAULT(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef STATELESS_PIPE_SAT_EN
        .sat_cfg_we(sat_cfg_we),
        .sat_cfg   (sat_cfg),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pkt_1     (pkt_1),
        .pkt_2     (pkt_2),
        .pkt_3     (pkt_3),
        .cons_1    (cons_1),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o_write   (o_write),
        .o_illegal (o_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [W-1:0] k;
        logic [W-1:0] res;
        logic         ill;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic on 64-bit values, reduced mod 2^32.
    function automatic logic [W:0] model(input int op, input longint unsigned a,
                                         input longint unsigned b,
                                         input longint unsigned c,
                                         input longint unsigned k,
                                         input bit sat);
        longint unsigned r;
        bit ill;
        r   = 0;
        ill = 1'b0;
        case (op)
            0, 5: begin
                r = a + ((op == 5) ? k : b);
                if (r > MAXV) r = sat ? MAXV : r - (MAXV + 1);
            end
            1, 6: begin
                longint unsigned rhs;
                rhs = (op == 6) ? k : b;
                if (a >= rhs) r = a - rhs;
                else r = sat ? 0 : a + (MAXV + 1) - rhs;
            end
            2: r = a & b;
            3: r = a ^ b;
            4: r = a | b;
            7: r = (a == b) ? 1 : 0;
            8: r = (a != b) ? 1 : 0;
            9: r = (a >= b) ? 1 : 0;
            10: r = (a < b) ? 1 : 0;
            11: r = (k >= W) ? 0 : ((a << k) & MAXV);
            12: r = (k >= W) ? 0 : (a >> k);
            13: r = (a != 0) ? b : c;
            default: ill = 1'b1;
        endcase
        return {ill, r[W-1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
`ifdef STATELESS_PIPE_SAT_EN
        if (sat_cfg_we) m_sat = sat_cfg;
`endif
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic [W-1:0] k);
        opcode = op;
        pkt_1  = a;
        pkt_2  = b;
        pkt_3  = c;
        cons_1 = k;
    endtask

    task automatic apply_one(input string name, input vec_t v);
        out_ready = 1'b1;
        drive(v.op, v.a, v.b, v.c, v.k);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check({name, ".valid"}, out_valid, 1);
        check({name, ".write"}, o_write, v.res);
        check({name, ".illegal"}, o_illegal, v.ill);
    endtask

    initial begin
        int acc;
        int got;
        int stale;
        bit fire;
        bit prev_stall;
        logic [W-1:0] prev_w;
        logic prev_ill;
        logic [W:0] q[$];
        logic [W:0] e;
        logic [W-1:0] strm_exp[4];
        logic [3:0]   strm_op[4];

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive(4'd0, '0, '0, '0, '0);
`ifdef STATELESS_PIPE_SAT_EN
        sat_cfg_we = 1'b0;
        sat_cfg = 1'b0;
`endif
        tick();
        rst = 1'b0;
        m_sat = 1'b0;
        check("reset.out_valid", out_valid, 0);
        check("reset.o_write", o_write, 0);
        check("reset.o_illegal", o_illegal, 0);
        check("reset.in_ready", in_ready, 1);

        tbl[0]  = '{4'd0,  32'd5,        32'd7,      32'd0, 32'd0,        32'd12,        1'b0};
        tbl[1]  = '{4'd1,  32'd3,        32'd5,      32'd0, 32'd0,        32'hFFFFFFFE,  1'b0};
        tbl[2]  = '{4'd2,  32'hF0F0,     32'hFF00,   32'd0, 32'd0,        32'hF000,      1'b0};
        tbl[3]  = '{4'd3,  32'hFF00,     32'h0FF0,   32'd0, 32'd0,        32'hF0F0,      1'b0};
        tbl[4]  = '{4'd4,  32'hF000,     32'h000F,   32'd0, 32'd0,        32'hF00F,      1'b0};
        tbl[5]  = '{4'd5,  32'd10,       32'd0,      32'd0, 32'hFFFFFFFF, 32'd9,         1'b0};
        tbl[6]  = '{4'd6,  32'd2,        32'd0,      32'd0, 32'd3,        32'hFFFFFFFF,  1'b0};
        tbl[7]  = '{4'd7,  32'd5,        32'd5,      32'd0, 32'd0,        32'd1,         1'b0};
        tbl[8]  = '{4'd8,  32'd5,        32'd5,      32'd0, 32'd0,        32'd0,         1'b0};
        tbl[9]  = '{4'd9,  32'd3,        32'd5,      32'd0, 32'd0,        32'd0,         1'b0};
        tbl[10] = '{4'd10, 32'd3,        32'd5,      32'd0, 32'd0,        32'd1,         1'b0};
        tbl[11] = '{4'd11, 32'd1,        32'd0,      32'd0, 32'd31,       32'h80000000,  1'b0};
        tbl[12] = '{4'd11, 32'd1,        32'd0,      32'd0, 32'd32,       32'd0,         1'b0};
        tbl[13] = '{4'd12, 32'h80000000, 32'd0,      32'd0, 32'd40,       32'd0,         1'b0};
        tbl[14] = '{4'd12, 32'h80000000, 32'd0,      32'd0, 32'd4,        32'h08000000,  1'b0};
        tbl[15] = '{4'd13, 32'd0,        32'd5,      32'd9, 32'd0,        32'd9,         1'b0};
        tbl[16] = '{4'd13, 32'd3,        32'd5,      32'd9, 32'd0,        32'd5,         1'b0};
        tbl[17] = '{4'd14, 32'd3,        32'd5,      32'd9, 32'd1,        32'd0,         1'b1};
        tbl[18] = '{4'd15, 32'hFFFF,     32'hFFFF,   32'd9, 32'd1,        32'd0,         1'b1};
        tbl[19] = '{4'd9,  32'd5,        32'd5,      32'd0, 32'd0,        32'd1,         1'b0};

        for (int i = 0; i < 20; i++) begin
            apply_one($sformatf("vec%0d", i), tbl[i]);
        end
        tick();
        tick();

        // back-to-back stream, one result per cycle
        strm_op  = '{4'd1, 4'd9, 4'd10, 4'd13};
        strm_exp = '{32'hFFFFFFFE, 32'd0, 32'd1, 32'd5};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                drive(strm_op[i], 32'd3, 32'd5, 32'd9, 32'd0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (i >= 2) begin
                check($sformatf("stream%0d.valid", i - 2), out_valid, 1);
                check($sformatf("stream%0d.write", i - 2), o_write, strm_exp[i-2]);
            end
            tick();
        end
        tick();

        // backpressure: only two bundles fit
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            drive(4'd0, 32'd100 + 32'(acc), 32'd1, 32'd0, 32'd0);
            in_valid = 1'b1;
            fire = in_ready;
            tick();
            if (fire) acc++;
        end
        check("bp.accepted", acc, 2);
        check("bp.in_ready", in_ready, 0);
        check("bp.out_valid", out_valid, 1);
        check("bp.hold", o_write, 101);
        out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            if (acc < 4) begin
                drive(4'd0, 32'd100 + 32'(acc), 32'd1, 32'd0, 32'd0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            fire = in_valid && in_ready;
            if (out_valid) begin
                check($sformatf("bp.out%0d", got), o_write, 101 + got);
                got++;
            end
            tick();
            if (fire) acc++;
        end
        in_valid = 1'b0;
        check("bp.received", got, 4);
        tick();

        // reset with both stages full
        out_ready = 1'b0;
        drive(4'd3, 32'hAAAA, 32'h5555, 32'd0, 32'd0);
        in_valid = 1'b1;
        tick();
        drive(4'd4, 32'h1234, 32'h4321, 32'd0, 32'd0);
        tick();
        in_valid = 1'b0;
        check("rst.full", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_sat = 1'b0;
        check("rst.out_valid", out_valid, 0);
        check("rst.o_write", o_write, 0);
        check("rst.o_illegal", o_illegal, 0);
        check("rst.in_ready", in_ready, 1);
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) stale++;
            tick();
        end
        check("rst.no_stale", stale, 0);

`ifdef STATELESS_PIPE_SAT_EN
        sat_cfg_we = 1'b1;
        sat_cfg = 1'b1;
        tick();
        sat_cfg_we = 1'b0;
        apply_one("sat.add", '{4'd0, 32'hFFFFFFF0, 32'h20, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0});
        apply_one("sat.subk", '{4'd6, 32'd2, 32'd0, 32'd0, 32'd3, 32'd0, 1'b0});
        apply_one("sat.sub", '{4'd1, 32'd3, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0});
        apply_one("sat.addk", '{4'd5, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0});
        sat_cfg = 1'b0;
        sat_cfg_we = 1'b1;
        tick();
        sat_cfg_we = 1'b0;
        apply_one("wrap.add", '{4'd0, 32'hFFFFFFF0, 32'h20, 32'd0, 32'd0, 32'h10, 1'b0});
        apply_one("wrap.subk", '{4'd6, 32'd2, 32'd0, 32'd0, 32'd3, 32'hFFFFFFFF, 1'b0});
        // enabling saturation in the capture cycle must not affect that bundle
        drive(4'd0, 32'hFFFFFFF0, 32'h20, 32'd0, 32'd0);
        in_valid = 1'b1;
        sat_cfg = 1'b1;
        sat_cfg_we = 1'b1;
        tick();
        in_valid = 1'b0;
        sat_cfg_we = 1'b0;
        tick();
        check("sat.inflight", o_write, 32'h10);
        sat_cfg = 1'b0;
        sat_cfg_we = 1'b1;
        tick();
        sat_cfg_we = 1'b0;
`endif

        // randomized scoreboard run
        prev_stall = 1'b0;
        prev_w = '0;
        prev_ill = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            opcode    = 4'($urandom_range(0, 15));
            pkt_1 = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 8)) : W'($urandom());
            pkt_2 = ($urandom_range(0, 3) == 0) ? pkt_1 : W'($urandom());
            pkt_3 = W'($urandom());
            cons_1 = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 40)) : W'($urandom());
`ifdef STATELESS_PIPE_SAT_EN
            sat_cfg_we = ($urandom_range(0, 15) == 0);
            sat_cfg = 1'($urandom_range(0, 1));
`endif
            #1;
            if (prev_stall) begin
                check("rnd.hold_valid", out_valid, 1);
                check("rnd.hold_write", o_write, prev_w);
                check("rnd.hold_ill", o_illegal, prev_ill);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rnd.spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("rnd.write", o_write, e[W-1:0]);
                    check("rnd.illegal", o_illegal, e[W]);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(int'(opcode), pkt_1, pkt_2, pkt_3, cons_1, m_sat));
            end
            check("rnd.inflight_le2", (q.size() <= 2), 1);
            prev_stall = out_valid && !out_ready;
            prev_w = o_write;
            prev_ill = o_illegal;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
`ifdef STATELESS_PIPE_SAT_EN
        sat_cfg_we = 1'b0;
`endif
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            #1;
            if (out_valid) begin
                e = q.pop_front();
                check("drain.write", o_write, e[W-1:0]);
                check("drain.illegal", o_illegal, e[W]);
            end
            tick();
        end
        check("drain.empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stateless_pipe.md
Name: stateless_pipe

Overview:
Pipelined, parametrised successor to the single-cycle stateless packet-field ALU atom. It computes the same opcode set (arithmetic, logical, constant, relational, shift, conditional) over WIDTH-bit packet fields. Results are registered through a two-stage pipeline with valid/ready flow control, so atoms can be chained inside a pipeline stage without long combinational paths. It also flags illegal opcodes instead of leaving the result undefined.

Parameters:
WIDTH, 32, width of packet fields, constant and result (>= 2)
SAT_EN_DEFAULT, 0, when the optional feature is compiled in, selects the reset value of the saturation-enable register (0 = wrap, 1 = saturate)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand bundle valid
in_ready  output  1  stage-1 can accept the bundle this cycle
pkt_1  input  WIDTH  operand A
pkt_2  input  WIDTH  operand B
pkt_3  input  WIDTH  operand C (conditional false arm)
cons_1  input  WIDTH  immediate constant / shift amount
opcode  input  4  operation select
out_valid  output  1  o_write/o_illegal valid
out_ready  input  1  downstream accepts result
o_write  output  WIDTH  result
o_illegal  output  1  result came from opcode 14 or 15

Behaviour:
- Reset: one clk with rst=1 clears s1_valid and s2_valid. out_valid=0, o_write=0, o_illegal=0. in_ready=1 the cycle after reset.
- Reset mid-operation: in-flight bundles are discarded, with no partial output.
- Stage 1 register: captures {pkt_1, pkt_2, pkt_3, cons_1, opcode} when in_valid && in_ready.
- Stage 2 register: computes and registers the result from the stage-1 contents.
- Stage 2 advance: s2 loads when s1_valid && (!s2_valid || out_ready).
- Ready: in_ready = !s1_valid || s2 advancing this cycle. It is combinational from out_ready, and there is no combinational in->out path.
- Latency: 2 cycles from accepted input to out_valid. Throughput is 1 per cycle when out_ready is held at 1.
- Backpressure: while out_valid && !out_ready, o_write, o_illegal and out_valid hold stable. At most 2 bundles are in flight; no bundle is dropped or duplicated.
- Opcodes, all unsigned:
  - 0 A+B, 1 A-B (wrap mod 2^WIDTH).
  - 2 A&B, 3 A^B, 4 A|B.
  - 5 A+cons_1, 6 A-cons_1.
  - 7 A==B, 8 A!=B, 9 A>=B, 10 A<B. These produce a 1-bit result, zero-extended to WIDTH.
  - 11 A<<cons_1, 12 A>>cons_1 (logical). If cons_1 >= WIDTH the result is 0.
  - 13: A!=0 ? B : C.
  - 14, 15: o_write=0, o_illegal=1. For all other opcodes o_illegal=0.
- Simultaneous accept and output-drain in one cycle is legal and must not stall.

Optional Feature:
Macro STATELESS_PIPE_SAT_EN.
- Defined: adds an input port sat_cfg_we (1) and sat_cfg (1), plus an internal sat_en register.
  - sat_en resets to SAT_EN_DEFAULT and is loaded with sat_cfg when sat_cfg_we=1.
  - sat_en is sampled per bundle at stage-1 capture, so a change never alters bundles already in flight.
  - When sat_en=1, opcodes 0 and 5 clamp to 2^WIDTH-1 on carry-out, and opcodes 1 and 6 clamp to 0 on borrow.
- Undefined: the ports and register do not exist, and all add/sub wrap.

Test Plan:
- WIDTH=32, out_ready=1, opcode=0, A=5, B=7, in_valid pulsed at cycle 0 -> out_valid=1 at cycle 2, o_write=12, o_illegal=0.
- Stream opcodes 1, 9, 10, 13 back-to-back with A=3, B=5, C=9 -> consecutive outputs 0xFFFFFFFE, 0, 1, 5 on cycles 2-5, with no bubbles.
- opcode 11 with A=1: cons_1=31 -> 0x80000000; cons_1=32 -> 0. opcode 12 with A=0x80000000, cons_1=40 -> 0. opcode 15 -> o_write=0, o_illegal=1.
- Backpressure: out_ready=0 for 5 cycles while driving 4 bundles -> exactly 2 accepted, in_ready=0 afterwards, and the output holds the first result. Release out_ready -> all 4 results emerge in order, with none lost.
- rst asserted while 2 bundles are in flight -> the next cycle has out_valid=0, o_write=0, in_ready=1, and no stale result ever appears.
- With STATELESS_PIPE_SAT_EN and sat_en=1: opcode 0 with A=0xFFFFFFF0, B=0x20 -> 0xFFFFFFFF; opcode 6 with A=2, cons_1=3 -> 0. With sat_en=0, the same stimulus gives 0x10 and 0xFFFFFFFF.
